// File: rtl/int_stream_rr_arb.sv
// int_stream_rr_arb: bounded-burst round-robin arbiter of NUM_IN valid/ready integer streams
// into a one-entry registered output stage tagged with the source index.
module int_stream_rr_arb #(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4,
  parameter int SW        = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SW-1:0]           out_src,
  output logic [31:0]             xfer_count
);
  localparam int BW = $clog2(BURST_MAX + 1);
  logic [SW-1:0] owner, sel;
  logic [BW-1:0] burst_cnt;
  logic          burst_ok, any, hs;
  assign burst_ok = burst_cnt < BW'(BURST_MAX);
  assign any      = |in_valid;
  assign hs       = rstn && (!out_valid || out_ready) && any;
  // Descending scan so the nearest valid input after owner wins; owner itself is checked last.
  always_comb begin
    sel = owner;
    for (int k = NUM_IN; k >= 1; k--)
      if (in_valid[(int'(owner) + k) % NUM_IN]) sel = SW'((int'(owner) + k) % NUM_IN);
    if (in_valid[owner] && burst_ok) sel = owner;
    in_ready = '0;
    if (hs) in_ready[sel] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      xfer_count <= '0;
      owner      <= SW'(NUM_IN - 1);
      burst_cnt  <= BW'(BURST_MAX);
    end else begin
      if (hs) begin
        out_valid <= 1'b1;
        out_data  <= in_data[sel*WIDTH +: WIDTH];
        out_src   <= sel;
        if (sel == owner && burst_ok) burst_cnt <= burst_cnt + BW'(1);
        else begin
          owner     <= sel;
          burst_cnt <= BW'(1);
        end
      end else if (out_ready) out_valid <= 1'b0;
      if (out_valid && out_ready) xfer_count <= xfer_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_int_stream_rr_arb.sv
// tb_int_stream_rr_arb: directed scenario tests for int_stream_rr_arb (NUM_IN=4, BURST_MAX=4).
module tb_int_stream_rr_arb;
  localparam int N = 4, W = 32, SW = 2;
  logic clk = 0, rstn = 0, out_ready = 0;
  logic [N-1:0] in_valid = '0, in_ready;
  logic [N*W-1:0] in_data = '0;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_src;
  logic [31:0] xfer_count;
  int n_vec = 0, n_err = 0;
  logic [3:0]  bp_v [10] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h0};
  logic        bp_o [10] = '{1, 0, 0, 1, 0, 1, 1, 1, 0, 1};
  logic [3:0]  bp_r [10] = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h8, 4'h0, 4'h0};
  logic [31:0] bp_d [10] = '{'h100, 'h100, 'h100, 'h101, 'h101, 'h102, 'h103, 'h400, 'h400, 'h400};
  logic [1:0]  bp_s [10] = '{0, 0, 0, 0, 0, 0, 0, 3, 3, 3};
  logic [31:0] bp_x [10] = '{0, 0, 0, 1, 1, 2, 3, 4, 4, 5};

  int_stream_rr_arb #(.NUM_IN(N), .WIDTH(W), .BURST_MAX(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(base + i);
  endtask

  task automatic do_reset();
    rstn = 0;
    in_valid = '0;
    step();
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0; in_valid = '1; out_ready = 1; set_lanes(7);
    for (int c = 0; c < 3; c++) begin
      #2;
      n_vec++; if (in_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready c=%0d got %h exp 0", c, in_ready); end
      step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_vec++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_data got %0d exp 0", out_data); end
    n_vec++; if (out_src !== 2'd0) begin n_err++; $display("FAIL reset_src got %0d exp 0", out_src); end
    n_vec++; if (xfer_count !== 32'd0) begin n_err++; $display("FAIL reset_xfer got %0d exp 0", xfer_count); end
  endtask

  task automatic test_single();
    rstn = 1; in_valid = 4'b0100; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_data[2*W +: W] = 32'(10 + k);
      #2;
      n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready k=%0d got %h exp 4", k, in_ready); end
      step();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid k=%0d got %b exp 1", k, out_valid); end
      n_vec++; if (out_data !== 32'(10 + k)) begin n_err++; $display("FAIL single_data k=%0d got %0d exp %0d", k, out_data, 10 + k); end
      n_vec++; if (out_src !== 2'd2) begin n_err++; $display("FAIL single_src k=%0d got %0d exp 2", k, out_src); end
    end
    in_valid = '0;
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b exp 0", out_valid); end
    n_vec++; if (xfer_count !== 32'd3) begin n_err++; $display("FAIL single_xfer got %0d exp 3", xfer_count); end
  endtask

  task automatic test_contention();
    do_reset();
    in_valid = '1; out_ready = 1; set_lanes(100);
    for (int k = 0; k < 17; k++) begin
      step();
      n_vec++; if (out_src !== 2'((k / 4) % 4)) begin n_err++; $display("FAIL cont_src k=%0d got %0d exp %0d", k, out_src, (k / 4) % 4); end
      n_vec++; if (out_data !== 32'(100 + (k / 4) % 4)) begin n_err++; $display("FAIL cont_data k=%0d got %0d exp %0d", k, out_data, 100 + (k / 4) % 4); end
    end
    n_vec++; if (xfer_count !== 32'd16) begin n_err++; $display("FAIL cont_xfer got %0d exp 16", xfer_count); end
  endtask

  task automatic test_lone();
    in_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      #2;
      n_vec++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL lone_ready k=%0d got %h exp 2", k, in_ready); end
      step();
      n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin n_err++; $display("FAIL lone_out k=%0d got v=%b s=%0d exp v=1 s=1", k, out_valid, out_src); end
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    int seq0 = 0, seq3 = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      in_valid = bp_v[c]; out_ready = bp_o[c];
      in_data[0 +: W] = 32'('h100 + seq0);
      in_data[3*W +: W] = 32'('h400 + seq3);
      #2;
      n_vec++; if (in_ready !== bp_r[c]) begin n_err++; $display("FAIL bp_ready c=%0d got %h exp %h", c, in_ready, bp_r[c]); end
      if (bp_r[c][0]) seq0++;
      if (bp_r[c][3]) seq3++;
      step();
      n_vec++; if (out_valid !== (c != 9)) begin n_err++; $display("FAIL bp_valid c=%0d got %b exp %b", c, out_valid, c != 9); end
      n_vec++; if (out_data !== bp_d[c] || out_src !== bp_s[c]) begin n_err++; $display("FAIL bp_out c=%0d got %h/%0d exp %h/%0d", c, out_data, out_src, bp_d[c], bp_s[c]); end
      n_vec++; if (xfer_count !== bp_x[c]) begin n_err++; $display("FAIL bp_xfer c=%0d got %0d exp %0d", c, xfer_count, bp_x[c]); end
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b0100; out_ready = 0; in_data[2*W +: W] = 32'd55;
    #2;
    n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL mid_load_ready got %h exp 4", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 32'd55) begin n_err++; $display("FAIL mid_load got v=%b s=%0d d=%0d exp 1/2/55", out_valid, out_src, out_data); end
    rstn = 0; in_valid = '1;
    #2;
    n_vec++; if (in_ready !== 4'h0) begin n_err++; $display("FAIL mid_rst_ready got %h exp 0", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 32'd0) begin n_err++; $display("FAIL mid_rst_out got v=%b s=%0d d=%0d exp 0/0/0", out_valid, out_src, out_data); end
    n_vec++; if (xfer_count !== 32'd0) begin n_err++; $display("FAIL mid_rst_xfer got %0d exp 0", xfer_count); end
    rstn = 1; out_ready = 1; set_lanes(100);
    #2;
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL mid_rel_ready got %h exp 1", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'd100) begin n_err++; $display("FAIL mid_rel_out got v=%b s=%0d d=%0d exp 1/0/100", out_valid, out_src, out_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lone();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/int_stream_rr_arb.md
# int_stream_rr_arb

Round-robin arbiter that shares one downstream integer consumer (an accumulator or summer) between NUM_IN valid/ready integer producers. It selects one requesting input per cycle with a bounded-burst round-robin policy and registers the winner into a one-entry output stage. The output carries the data word and its source index. Raw flattened ports let it sit between hand-coded producers and an ESI channel wrapper.

## Interface
- NUM_IN, 4, number of requesting input channels (2..16)
- WIDTH, 32, data width per channel
- BURST_MAX, 4, max consecutive transfers granted to one input while others wait (>=1)
- SW = $clog2(NUM_IN), derived width of the source index
- clk  input  1  clock, all logic on posedge
- rstn  input  1  reset, synchronous, active-low
- in_valid  input  NUM_IN  per-input valid
- in_ready  output  NUM_IN  per-input ready
- in_data  input  NUM_IN*WIDTH  input i at bits [i*WIDTH +: WIDTH]
- out_valid  output  1  output stage holds a word
- out_ready  input  1  downstream ready
- out_data  output  WIDTH  granted word
- out_src  output  SW  index of the input that supplied out_data
- xfer_count  output  32  number of output handshakes since reset, wraps at 2^32

## Operation
- State: owner (SW bits), burst_cnt ($clog2(BURST_MAX+1) bits), output register (out_valid, out_data, out_src), xfer_count.
- can_load = !out_valid || out_ready.
- Selection (combinational), sel:
  - If in_valid[owner] && burst_cnt < BURST_MAX, then sel = owner.
  - Otherwise sel = first valid input scanning owner+1, owner+2, …, owner+NUM_IN, modulo NUM_IN. Owner is checked last.
  - If no input is valid, there is no selection.
- in_ready[i] = rstn && can_load && (some input valid) && sel == i. At most one bit is set. in_ready may depend on in_valid. Producers' valid must not depend on ready.
- Input handshake on i (in_valid[i] && in_ready[i]):
  - out_data <= in_data[i], out_src <= i, out_valid <= 1.
  - If i == owner && burst_cnt < BURST_MAX, then burst_cnt <= burst_cnt + 1.
  - Otherwise owner <= i, burst_cnt <= 1.
- No input handshake and out_valid && out_ready: out_valid <= 0. out_data and out_src hold their last values.
- owner and burst_cnt change only on input handshakes. Idle cycles do not refresh a burst.
- Output handshake (out_valid && out_ready): xfer_count <= xfer_count + 1, wrapping.
- Lone requester: when its burst expires and no other input is valid, it wins again through the wrap-around scan and burst_cnt restarts at 1. There is no bubble.
- Reset (rstn=0 on a clock edge) sets:
  - out_valid=0, out_data=0, out_src=0, xfer_count=0
  - owner=NUM_IN-1, burst_cnt=BURST_MAX, so the first grant scans from input 0
- Reset mid-operation: a pending output word is discarded. No handshake completes in a reset cycle.

## Timing
- Latency is 1 cycle: an input handshake at edge N produces out_valid=1 with that data after edge N.
- Throughput is 1 word/cycle with out_ready held high. Loading and draining happen in the same cycle.
- Backpressure: with out_valid=1 && out_ready=0, all in_ready=0, and out_data/out_src stay stable until the handshake.
- Combinational path in_valid -> in_ready passes through the priority scan. There is no path out_ready -> out_valid.
- in_ready=0 on every cycle where rstn=0.
- Fairness bound: a continuously valid input waits at most (NUM_IN-1)*BURST_MAX transfers between its grants.

## Test plan
- Reset: hold rstn=0 for 3 cycles with all in_valid=1. Then out_valid=0, out_data=0, out_src=0, xfer_count=0, and in_ready=0 every cycle.
- Single stream: only input 2 valid, data 10,11,12, out_ready=1. Outputs are 10,11,12 on consecutive cycles, each 1 cycle after its input handshake, with out_src=2 and final xfer_count=3.
- Contention: NUM_IN=4, BURST_MAX=4, all inputs valid, out_ready=1. out_src sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…
- Lone requester: only input 1 valid for 10 transfers. All 10 are granted back-to-back with out_src=1 and no bubble at burst expiry.
- Backpressure: inputs 0 and 3 valid, out_ready toggles 1,0,0,1,0,1. out_data is stable while out_ready=0, and in_ready is all zero then. The output sequence matches the accepted input order with no loss or duplication. xfer_count equals the number of output handshakes.
- Reset mid-burst: rstn=0 for 1 cycle while out_valid=1 and input 2 owns the grant. Next cycle out_valid=0. After release with all inputs valid, the first out_src is 0.
